// File: rtl/alu_acc_seq.sv
// rtl/alu_acc_seq.sv - 8-bit accumulator sequencer with Z/N/C flags and an iterative shift-add MUL
module alu_acc_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] op,
   input  logic [7:0] operand,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] result,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_c,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_SUB  = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  opnd_q, opnd_d;
   logic [7:0]  acc_q, acc_d;
   logic [15:0] prod_q, prod_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        z_q, z_d;
   logic        n_q, n_d;
   logic        c_q, c_d;

   logic [8:0]  alu9;
   logic [8:0]  sum9;
   logic [15:0] prod_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         opnd_q  <= 8'h00;
         acc_q   <= 8'h00;
         prod_q  <= 16'h0000;
         cnt_q   <= 3'd0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         n_q     <= n_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      z_d      = z_q;
      n_d      = n_q;
      c_d      = c_q;
      alu9     = 9'd0;
      sum9     = 9'd0;
      prod_nxt = prod_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d   = op;
               opnd_d = operand;
               cnt_d  = 3'd0;
               // multiplier sits in the low half and is shifted out as the product grows
               prod_d = {8'h00, operand};
               state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_LOAD: alu9 = {1'b0, opnd_q};
               OP_AND:  alu9 = {1'b0, acc_q & opnd_q};
               OP_OR:   alu9 = {1'b0, acc_q | opnd_q};
               OP_XOR:  alu9 = {1'b0, acc_q ^ opnd_q};
               OP_ADD:  alu9 = {1'b0, acc_q} + {1'b0, opnd_q};
               OP_SUB:  alu9 = {1'b0, acc_q} + {1'b0, ~opnd_q} + 9'd1;
               OP_NOT:  alu9 = {1'b0, ~acc_q};
               default: alu9 = {1'b0, acc_q};
            endcase
            acc_d   = alu9[7:0];
            c_d     = alu9[8];
            z_d     = (alu9[7:0] == 8'h00);
            n_d     = alu9[7];
            state_d = S_DONE;
         end
         S_MUL: begin
            sum9     = {1'b0, prod_q[15:8]} + {1'b0, (prod_q[0] ? acc_q : 8'h00)};
            prod_nxt = {sum9, prod_q[7:1]};
            prod_d   = prod_nxt;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               acc_d   = prod_nxt[7:0];
               c_d     = |prod_nxt[15:8];
               z_d     = (prod_nxt[7:0] == 8'h00);
               n_d     = prod_nxt[7];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_EXEC) || (state_q == S_MUL);
   assign result    = acc_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_c    = c_q;

endmodule
